// File: rtl/mouse_axis_emu_if.sv
// mouse_axis_emu_if
//   Bundles the host-side inputs (PS/2 mouse packet, real analog and digital
//   joystick, CPU halt, Y inversion) and the player-1 outputs to the core.
//
//   master : the host side (hps_io / testbench). It drives the inputs and
//            observes the outputs.
//   slave  : the mouse emulator. It consumes the inputs and drives the
//            outputs.
//
//   PS2_MOUSE  [24] toggle strobe, [23:16] dY, [15:8] dX, [7:0] flags
//   JOYA       real analog stick {Y[15:8], X[7:0]}, signed
//   JOY_IN     real digital joystick bits
//   CPU_HALT   high while the OSD or loader owns the machine
//   INVERT_Y   1 = subtract dY instead of adding it
//   AXIS_X/Y   signed axes to the core
//   JOY_OUT    digital bits to the core
//   EMU_ACTIVE 1 = mouse emulation currently owns player 1
interface mouse_axis_emu_if;
    logic [24:0] PS2_MOUSE;
    logic [15:0] JOYA;
    logic [20:0] JOY_IN;
    logic        CPU_HALT;
    logic        INVERT_Y;
    logic [7:0]  AXIS_X;
    logic [7:0]  AXIS_Y;
    logic [20:0] JOY_OUT;
    logic        EMU_ACTIVE;

    modport master (
        output PS2_MOUSE, JOYA, JOY_IN, CPU_HALT, INVERT_Y,
        input  AXIS_X, AXIS_Y, JOY_OUT, EMU_ACTIVE
    );

    modport slave (
        input  PS2_MOUSE, JOYA, JOY_IN, CPU_HALT, INVERT_Y,
        output AXIS_X, AXIS_Y, JOY_OUT, EMU_ACTIVE
    );
endinterface

// File: rtl/mouse_axis_emu.sv
// mouse_axis_emu
//   Turns PS/2 mouse movement into an emulated signed analog stick for
//   player 1 and maps the mouse buttons onto the player-1 fire bits.
//   Whenever the real analog stick leaves centre or the CPU is halted the
//   block hands player 1 back to the real controls (passthrough).
//
//   Pipeline:
//     E0  packet seen (strobe toggled): delta scaled, clamped, registered
//     E1  delta added to the saturating accumulators, emulation engaged
//     E2  output registers pick accumulator or passthrough values
//
//   Ports:
//     CLK      system clock
//     RESET_N  synchronous, active-low reset
//     bus      mouse_axis_emu_if.slave (see the interface for signal list)
//
//   Parameters:
//     DELTA_SHIFT   arithmetic right shift applied to every raw delta
//     DELTA_LIMIT   magnitude clamp on each scaled delta (1..127)
//     DECAY_EN      nonzero enables auto-centre while the mouse is idle
//     DECAY_PERIOD  cycles per one-step decay toward centre (>= 2)
module mouse_axis_emu #(
    parameter int DELTA_SHIFT  = 1,
    parameter int DELTA_LIMIT  = 10,
    parameter int DECAY_EN     = 0,
    parameter int DECAY_PERIOD = 1000000
) (
    input  logic            CLK,
    input  logic            RESET_N,
    mouse_axis_emu_if.slave bus
);

    localparam int                    CNT_W    = $clog2(DECAY_PERIOD);
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DECAY_PERIOD - 1);
    localparam logic signed [8:0]     LIM_POS  = 9'(DELTA_LIMIT);
    localparam logic signed [8:0]     LIM_NEG  = -LIM_POS;

    logic                    old_stb;
    logic                    v1;
    logic signed [8:0]       d1_x;
    logic signed [8:0]       d1_y;
    logic [1:0]              btn_latch;
    logic signed [7:0]       acc_x;
    logic signed [7:0]       acc_y;
    logic                    emu_active;
    logic [CNT_W-1:0]        decay_cnt;
    logic [7:0]              axis_x;
    logic [7:0]              axis_y;
    logic [20:0]             joy_out;

    logic                    pkt;
    logic                    release_req;
    logic                    decay_wrap;
    logic signed [8:0]       dy_eff;
    logic signed [9:0]       sum_x;
    logic signed [9:0]       sum_y;
    logic                    unused_flags;

    // Sign-extend the 8-bit magnitude with its flag bit, scale it down and
    // clamp it so that a single fast swipe cannot slam the stick.
    function automatic logic signed [8:0] scale_delta(input logic sign_bit,
                                                      input logic [7:0] mag);
        logic signed [8:0] raw;
        logic signed [8:0] shifted;
        raw     = {sign_bit, mag};
        shifted = raw >>> DELTA_SHIFT;
        if (shifted > LIM_POS)
            return LIM_POS;
        else if (shifted < LIM_NEG)
            return LIM_NEG;
        return shifted;
    endfunction

    // The sum is formed one bit wider than needed so it can be clipped
    // instead of wrapping from full right to full left.
    function automatic logic signed [7:0] sat8(input logic signed [9:0] sum);
        if (sum > 10'sd127)
            return 8'h7F;
        else if (sum < -10'sd128)
            return 8'h80;
        return sum[7:0];
    endfunction

    function automatic logic signed [7:0] toward_zero(input logic signed [7:0] v);
        if (v > 8'sd0)
            return v - 8'sd1;
        else if (v < 8'sd0)
            return v + 8'sd1;
        return v;
    endfunction

    assign pkt         = bus.PS2_MOUSE[24] != old_stb;
    assign release_req = (bus.JOYA != 16'h0000) || bus.CPU_HALT;
    assign dy_eff      = bus.INVERT_Y ? -d1_y : d1_y;
    assign sum_x       = 10'(acc_x) + 10'(d1_x);
    assign sum_y       = 10'(acc_y) + 10'(dy_eff);

    // A fresh packet restarts the idle period, so a packet landing on the
    // wrap cycle suppresses that decay step.
    assign decay_wrap  = (DECAY_EN != 0) && emu_active && !pkt &&
                         (decay_cnt == CNT_LAST);

    // Flag bits other than the signs and the two buttons carry nothing here.
    assign unused_flags = ^{bus.PS2_MOUSE[7:6], bus.PS2_MOUSE[3:2]};

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            old_stb    <= bus.PS2_MOUSE[24];
            v1         <= 1'b0;
            d1_x       <= '0;
            d1_y       <= '0;
            btn_latch  <= 2'b00;
            acc_x      <= '0;
            acc_y      <= '0;
            emu_active <= 1'b0;
            decay_cnt  <= '0;
            axis_x     <= '0;
            axis_y     <= '0;
            joy_out    <= '0;
        end else begin
            old_stb <= bus.PS2_MOUSE[24];

            // Outputs follow the ownership decided on the previous edge, so
            // a release shows up as passthrough one edge later.
            if (emu_active) begin
                axis_x  <= acc_x;
                axis_y  <= acc_y;
                joy_out <= {bus.JOY_IN[20:6], btn_latch, bus.JOY_IN[3:0]};
            end else begin
                axis_x  <= bus.JOYA[7:0];
                axis_y  <= bus.JOYA[15:8];
                joy_out <= bus.JOY_IN;
            end

            if (pkt) begin
                d1_x      <= scale_delta(bus.PS2_MOUSE[4], bus.PS2_MOUSE[15:8]);
                d1_y      <= scale_delta(bus.PS2_MOUSE[5], bus.PS2_MOUSE[23:16]);
                btn_latch <= bus.PS2_MOUSE[1:0];
            end

            // Real controls win over anything in flight, including a packet
            // that is about to be accumulated this very cycle.
            if (release_req) begin
                acc_x      <= '0;
                acc_y      <= '0;
                emu_active <= 1'b0;
                v1         <= 1'b0;
                decay_cnt  <= '0;
            end else begin
                v1 <= pkt;

                if (v1) begin
                    acc_x      <= sat8(sum_x);
                    acc_y      <= sat8(sum_y);
                    emu_active <= 1'b1;
                end else if (decay_wrap) begin
                    acc_x <= toward_zero(acc_x);
                    acc_y <= toward_zero(acc_y);
                end

                if ((DECAY_EN == 0) || !emu_active || pkt || decay_wrap)
                    decay_cnt <= '0;
                else
                    decay_cnt <= decay_cnt + 1'b1;
            end
        end
    end

    assign bus.AXIS_X     = axis_x;
    assign bus.AXIS_Y     = axis_y;
    assign bus.JOY_OUT    = joy_out;
    assign bus.EMU_ACTIVE = emu_active;

endmodule

// File: tb/tb_mouse_axis_emu.sv
// tb_mouse_axis_emu
//   Drives two emulator instances with identical inputs: instance a uses the
//   default parameters (no decay), instance b enables decay with a period of
//   four cycles. A behavioural model of each instance predicts the outputs
//   every cycle; directed sections add hand-computed expectations.
`timescale 1ns/1ps
module tb_mouse_axis_emu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [24:0] ps2_mouse;
    logic [15:0] joya;
    logic [20:0] joy_in;
    logic        cpu_halt;
    logic        invert_y;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mouse_axis_emu_if bus_a ();
    mouse_axis_emu_if bus_b ();

    assign bus_a.PS2_MOUSE = ps2_mouse;
    assign bus_a.JOYA      = joya;
    assign bus_a.JOY_IN    = joy_in;
    assign bus_a.CPU_HALT  = cpu_halt;
    assign bus_a.INVERT_Y  = invert_y;
    assign bus_b.PS2_MOUSE = ps2_mouse;
    assign bus_b.JOYA      = joya;
    assign bus_b.JOY_IN    = joy_in;
    assign bus_b.CPU_HALT  = cpu_halt;
    assign bus_b.INVERT_Y  = invert_y;

    mouse_axis_emu #(
        .DELTA_SHIFT (1),
        .DELTA_LIMIT (10),
        .DECAY_EN    (0),
        .DECAY_PERIOD(1000000)
    ) dut_a (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus_a)
    );

    mouse_axis_emu #(
        .DELTA_SHIFT (1),
        .DELTA_LIMIT (10),
        .DECAY_EN    (1),
        .DECAY_PERIOD(4)
    ) dut_b (
        .CLK    (clk),
        .RESET_N(rst_n),
        .bus    (bus_b)
    );

    // Behavioural model state, one entry per instance.
    bit          m_decay_en [2] = '{1'b0, 1'b1};
    int          m_period   [2] = '{1000000, 4};
    bit          m_old      [2];
    int          m_accx     [2];
    int          m_accy     [2];
    bit          m_active   [2];
    bit          m_pend     [2];
    int          m_pdx      [2];
    int          m_pdy      [2];
    bit [1:0]    m_btn      [2];
    int          m_idle     [2];
    logic [7:0]  exp_x      [2];
    logic [7:0]  exp_y      [2];
    logic [20:0] exp_joy    [2];
    bit          model_ready = 1'b0;

    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A mouse delta as a plain integer: signed 9-bit value, halved (floor),
    // then limited to +/-10.
    function automatic int model_delta(input bit sign_bit, input bit [7:0] mag);
        int v;
        v = sign_bit ? int'(mag) - 256 : int'(mag);
        v = v >>> 1;
        if (v > 10)  v = 10;
        if (v < -10) v = -10;
        return v;
    endfunction

    function automatic int clip(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int nudge(input int v);
        if (v > 0) return v - 1;
        if (v < 0) return v + 1;
        return v;
    endfunction

    task automatic model_step(input int i);
        bit pkt;
        bit rel;
        bit was_active;
        bit step_due;
        if (!rst_n) begin
            m_old[i]    = ps2_mouse[24];
            m_accx[i]   = 0;
            m_accy[i]   = 0;
            m_active[i] = 1'b0;
            m_pend[i]   = 1'b0;
            m_pdx[i]    = 0;
            m_pdy[i]    = 0;
            m_btn[i]    = 2'b00;
            m_idle[i]   = 0;
            exp_x[i]    = 8'h00;
            exp_y[i]    = 8'h00;
            exp_joy[i]  = '0;
            model_ready = 1'b1;
        end else begin
            pkt      = ps2_mouse[24] != m_old[i];
            m_old[i] = ps2_mouse[24];
            if (m_active[i]) begin
                exp_x[i]   = 8'(m_accx[i]);
                exp_y[i]   = 8'(m_accy[i]);
                exp_joy[i] = {joy_in[20:6], m_btn[i], joy_in[3:0]};
            end else begin
                exp_x[i]   = joya[7:0];
                exp_y[i]   = joya[15:8];
                exp_joy[i] = joy_in;
            end
            rel        = (joya != 16'h0000) || cpu_halt;
            was_active = m_active[i];
            if (rel) begin
                m_accx[i]   = 0;
                m_accy[i]   = 0;
                m_active[i] = 1'b0;
                m_idle[i]   = 0;
            end else begin
                step_due = m_decay_en[i] && was_active && !pkt &&
                           (m_idle[i] == m_period[i] - 1);
                if (m_pend[i]) begin
                    m_accx[i]   = clip(m_accx[i] + m_pdx[i]);
                    m_accy[i]   = clip(invert_y ? m_accy[i] - m_pdy[i]
                                                : m_accy[i] + m_pdy[i]);
                    m_active[i] = 1'b1;
                end else if (step_due) begin
                    m_accx[i] = nudge(m_accx[i]);
                    m_accy[i] = nudge(m_accy[i]);
                end
                if (!m_decay_en[i] || !was_active || pkt || step_due)
                    m_idle[i] = 0;
                else
                    m_idle[i] = m_idle[i] + 1;
            end
            m_pend[i] = pkt && !rel;
            if (pkt) begin
                m_pdx[i] = model_delta(ps2_mouse[4], ps2_mouse[15:8]);
                m_pdy[i] = model_delta(ps2_mouse[5], ps2_mouse[23:16]);
                m_btn[i] = ps2_mouse[1:0];
            end
        end
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++)
            model_step(i);
    end

    // Every negedge, both instances are compared with the model.
    always @(negedge clk) begin
        if (model_ready) begin
            check_output("a.axis_x",  {24'b0, bus_a.AXIS_X},     {24'b0, exp_x[0]});
            check_output("a.axis_y",  {24'b0, bus_a.AXIS_Y},     {24'b0, exp_y[0]});
            check_output("a.joy_out", {11'b0, bus_a.JOY_OUT},    {11'b0, exp_joy[0]});
            check_output("a.emu",     {31'b0, bus_a.EMU_ACTIVE}, {31'b0, m_active[0]});
            check_output("b.axis_x",  {24'b0, bus_b.AXIS_X},     {24'b0, exp_x[1]});
            check_output("b.axis_y",  {24'b0, bus_b.AXIS_Y},     {24'b0, exp_y[1]});
            check_output("b.joy_out", {11'b0, bus_b.JOY_OUT},    {11'b0, exp_joy[1]});
            check_output("b.emu",     {31'b0, bus_b.EMU_ACTIVE}, {31'b0, m_active[1]});
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Toggles the strobe with a new packet and advances one cycle.
    task automatic send_pkt(input logic [7:0] dx, input logic [7:0] dy,
                            input logic [7:0] flags);
        ps2_mouse = {~ps2_mouse[24], dy, dx, flags};
        @(negedge clk);
    endtask

    task automatic apply_stimulus(input int cycles);
        for (int n = 0; n < cycles; n++) begin
            if ($urandom_range(0, 99) < 40) begin
                ps2_mouse = {~ps2_mouse[24],
                             ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 24)) : 8'($urandom),
                             ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 24)) : 8'($urandom),
                             8'($urandom)};
            end
            joya     = ($urandom_range(0, 99) < 3) ? 16'($urandom) : 16'h0000;
            cpu_halt = $urandom_range(0, 99) < 2;
            if ($urandom_range(0, 19) == 0)
                invert_y = ~invert_y;
            joy_in   = 21'($urandom);
            rst_n    = $urandom_range(0, 199) != 0;
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        ps2_mouse = '0;
        joya      = 16'h3F20;
        joy_in    = '0;
        cpu_halt  = 1'b0;
        invert_y  = 1'b0;
        wait_cycles(3);
        check_output("reset axis_x", {24'b0, bus_a.AXIS_X},     32'h00);
        check_output("reset axis_y", {24'b0, bus_a.AXIS_Y},     32'h00);
        check_output("reset emu",    {31'b0, bus_a.EMU_ACTIVE}, 32'h0);

        rst_n = 1'b1;
        wait_cycles(1);
        check_output("pass axis_x", {24'b0, bus_a.AXIS_X},     32'h20);
        check_output("pass axis_y", {24'b0, bus_a.AXIS_Y},     32'h3F);
        check_output("pass emu",    {31'b0, bus_a.EMU_ACTIVE}, 32'h0);

        joya = 16'h0000;
        wait_cycles(2);
        send_pkt(8'h20, 8'h00, 8'h00);
        wait_cycles(2);
        check_output("first pkt x", {24'b0, bus_a.AXIS_X},     32'h0A);
        check_output("first pkt emu", {31'b0, bus_a.EMU_ACTIVE}, 32'h1);

        for (int k = 0; k < 13; k++)
            send_pkt(8'h20, 8'h00, 8'h00);
        wait_cycles(3);
        check_output("sat high x", {24'b0, bus_a.AXIS_X}, 32'h7F);
        for (int k = 0; k < 30; k++)
            send_pkt(8'hE0, 8'h00, 8'h10);
        wait_cycles(3);
        check_output("sat low x", {24'b0, bus_a.AXIS_X}, 32'h80);

        joy_in   = 21'h1ABCDE;
        invert_y = 1'b1;
        send_pkt(8'h00, 8'h08, 8'h01);
        wait_cycles(2);
        check_output("inv y", {24'b0, bus_a.AXIS_Y}, 32'hFC);
        check_output("btn joy", {11'b0, bus_a.JOY_OUT},
                     {11'b0, 21'h1ABCDE & ~21'h30 | 21'h10});
        invert_y = 1'b0;
        send_pkt(8'h00, 8'h08, 8'h01);
        wait_cycles(2);
        check_output("noninv y", {24'b0, bus_a.AXIS_Y}, 32'h00);

        send_pkt(8'h00, 8'h00, 8'h02);
        wait_cycles(2);
        check_output("btn only x", {24'b0, bus_a.AXIS_X}, 32'h80);
        check_output("btn only joy", {30'b0, bus_a.JOY_OUT[5:4]}, 32'h2);

        // Release through the real stick while a packet is in flight.
        cpu_halt = 1'b1;
        wait_cycles(1);
        cpu_halt = 1'b0;
        for (int k = 0; k < 5; k++)
            send_pkt(8'h20, 8'h00, 8'h00);
        wait_cycles(3);
        check_output("acc 50", {24'b0, bus_a.AXIS_X}, 32'h32);
        send_pkt(8'h20, 8'h00, 8'h00);
        joya = 16'h0001;
        wait_cycles(2);
        check_output("joya rel x",   {24'b0, bus_a.AXIS_X},     32'h01);
        check_output("joya rel emu", {31'b0, bus_a.EMU_ACTIVE}, 32'h0);
        joya = 16'h0000;
        wait_cycles(1);
        send_pkt(8'h20, 8'h00, 8'h00);
        wait_cycles(2);
        check_output("after joya rel", {24'b0, bus_a.AXIS_X}, 32'h0A);

        // Same release through CPU halt.
        cpu_halt = 1'b1;
        wait_cycles(1);
        cpu_halt = 1'b0;
        for (int k = 0; k < 5; k++)
            send_pkt(8'h20, 8'h00, 8'h00);
        wait_cycles(3);
        send_pkt(8'h20, 8'h00, 8'h00);
        cpu_halt = 1'b1;
        wait_cycles(1);
        cpu_halt = 1'b0;
        wait_cycles(1);
        check_output("halt rel x",   {24'b0, bus_a.AXIS_X},     32'h00);
        check_output("halt rel emu", {31'b0, bus_a.EMU_ACTIVE}, 32'h0);
        send_pkt(8'h20, 8'h00, 8'h00);
        wait_cycles(2);
        check_output("after halt rel", {24'b0, bus_a.AXIS_X}, 32'h0A);

        // Decay on instance b: (3,-2) -> (2,-1) -> (1,0) -> (0,0).
        cpu_halt = 1'b1;
        wait_cycles(1);
        cpu_halt = 1'b0;
        send_pkt(8'h06, 8'hFC, 8'h20);
        wait_cycles(2);
        check_output("decay0 x", {24'b0, bus_b.AXIS_X}, 32'h03);
        check_output("decay0 y", {24'b0, bus_b.AXIS_Y}, 32'hFE);
        wait_cycles(4);
        check_output("decay1 x", {24'b0, bus_b.AXIS_X}, 32'h02);
        check_output("decay1 y", {24'b0, bus_b.AXIS_Y}, 32'hFF);
        wait_cycles(4);
        check_output("decay2 x", {24'b0, bus_b.AXIS_X}, 32'h01);
        check_output("decay2 y", {24'b0, bus_b.AXIS_Y}, 32'h00);
        wait_cycles(4);
        check_output("decay3 x", {24'b0, bus_b.AXIS_X}, 32'h00);
        wait_cycles(8);
        check_output("decay rest", {24'b0, bus_b.AXIS_X}, 32'h00);
        check_output("no decay a", {24'b0, bus_a.AXIS_X}, 32'h03);

        // A packet on the wrap cycle skips that step and restarts the count.
        send_pkt(8'h06, 8'h00, 8'h00);
        wait_cycles(3);
        send_pkt(8'h02, 8'h00, 8'h00);
        wait_cycles(2);
        check_output("wrap skip x", {24'b0, bus_b.AXIS_X}, 32'h04);
        wait_cycles(3);
        check_output("wrap restart x", {24'b0, bus_b.AXIS_X}, 32'h03);

        apply_stimulus(3000);
        rst_n    = 1'b1;
        joya     = 16'h0000;
        cpu_halt = 1'b0;
        wait_cycles(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mouse_axis_emu.md
Name: mouse_axis_emu

Overview:
- Converts PS/2 mouse packets into emulated 8-bit signed analog stick axes for player 1.
- Maps mouse buttons onto the player-1 fire bits.
- Sits between hps_io (ps2_mouse, joystick_l_analog_0, joystick_0) and the atari5200top JOY1X/JOY1Y/JOY1 inputs.
- Falls back to passthrough whenever the real analog stick moves or the CPU halts.
- Adds registered pipelining, delta scaling/limiting, saturation and optional auto-centre decay.

Parameters:
- DELTA_SHIFT, 1: arithmetic right shift applied to each raw mouse delta.
- DELTA_LIMIT, 10: magnitude clamp on each scaled delta; valid range 1..127.
- DECAY_EN, 0: 1 enables the auto-centre return when the mouse is idle.
- DECAY_PERIOD, 1000000: CLK cycles per 1-step decay; valid range ≥2.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  synchronous, active-low reset.
- PS2_MOUSE  in  25  {[24] toggle strobe, [23:16] dY, [15:8] dX, [7:0] flags}. Flags: [5] Y sign, [4] X sign, [1:0] R/L buttons.
- JOYA  in  16  real analog stick {Y[15:8], X[7:0]}, signed.
- JOY_IN  in  21  real digital joystick bits.
- CPU_HALT  in  1  high = CPU halted (OSD/loader active).
- INVERT_Y  in  1  1 = subtract dY instead of adding it.
- AXIS_X  out  8  signed X to core.
- AXIS_Y  out  8  signed Y to core.
- JOY_OUT  out  21  digital bits to core.
- EMU_ACTIVE  out  1  1 = mouse emulation owns player 1.

Behaviour:

Reset (RESET_N low at a CLK edge):
- AXIS_X=0, AXIS_Y=0, JOY_OUT=0, EMU_ACTIVE=0.
- Accumulators, button latch, decay counter and stage-1 valid all cleared.
- old_stb loads PS2_MOUSE[24], so no spurious packet is seen on reset exit.

Packet detect:
- pkt = PS2_MOUSE[24] != old_stb.
- old_stb <= PS2_MOUSE[24] every cycle.

Stage 1 (edge E0, the edge at which pkt is true):
- Raw delta = 9-bit signed {sign, byte}.
- Shift: >>> DELTA_SHIFT.
- Clamp to [-DELTA_LIMIT, +DELTA_LIMIT].
- Register dX and dY (9-bit), the button latch from PS2_MOUSE[1:0], and v1=1.

Stage 2 (E1, when v1=1):
- accX += dX.
- accY += (INVERT_Y ? -dY : dY). INVERT_Y is sampled at E1.
- Arithmetic is 10-bit signed; result saturates to [-128, 127].
- EMU_ACTIVE <= 1.

Output register (E2):
- AXIS_X/Y <= EMU_ACTIVE ? acc : JOYA.
- JOY_OUT <= EMU_ACTIVE ? {JOY_IN[20:6], btn_latch, JOY_IN[3:0]} : JOY_IN.
- Packet-to-output latency: 3 edges. Passthrough latency: 1 edge.

Pipelining:
- Back-to-back packets (strobe toggling every cycle) are all accumulated in order; none are dropped.

Release condition (JOYA != 0 or CPU_HALT = 1), evaluated every cycle:
- EMU_ACTIVE <= 0, acc <= 0, v1 <= 0, decay counter <= 0.
- Release beats a stage-2 update in the same cycle; the in-flight packet is discarded.
- Output registers switch to passthrough on the next edge.

Decay (DECAY_EN=1, EMU_ACTIVE=1):
- The counter increments each cycle and clears on any pkt.
- When it reaches DECAY_PERIOD-1 it wraps to 0, and each nonzero acc moves 1 toward 0.
- A stage-2 update in the same cycle takes priority; the decay step is skipped.
- -128 steps to -127. An axis at 0 stays 0.

Boundaries:
- 0x00 deltas with button change: only the buttons update.
- Sign=1 with byte 0x00 gives -256 → shifted → clamped to -DELTA_LIMIT.
- Decay is inert when DECAY_EN=0.

Test Plan:
- Reset, JOYA=0x3F20, no packets → AXIS_X=0x20, AXIS_Y=0x3F one edge after reset release; EMU_ACTIVE=0.
- One packet with dX=0x20, X sign=0 (defaults) → AXIS_X=+10 (32>>1=16, clamped to 10) exactly 3 edges after the toggle; EMU_ACTIVE=1.
- 13 toggles on consecutive cycles, each dX=0x20 → AXIS_X saturates at 127 (0x7F) and never wraps. Then 30 packets with X sign=1, byte 0xE0 (-32→-16→-10) → AXIS_X=-128 (0x80).
- dY=0x08, Y sign=0, INVERT_Y=1, flags[1:0]=2'b01 → AXIS_Y=-4 (0xFC) and JOY_OUT[5:4]=2'b01 with the other bits from JOY_IN. Repeat with INVERT_Y=0 → AXIS_Y returns to 0.
- EMU_ACTIVE=1, accX=50; drive JOYA=0x0001 in the same cycle a stage-2 update is pending → the packet is discarded, acc=0, EMU_ACTIVE=0, AXIS_X=0x01 next edge. Repeat using CPU_HALT=1 instead of JOYA → same release.
- DECAY_EN=1, DECAY_PERIOD=4, accX=3, accY=-2, no packets → after 4 cycles (3,-2) becomes (2,-1), after 8 cycles (1,0), after 12 cycles (0,0) and stays 0. A packet in the wrap cycle → decay step skipped, counter restarts.
